// File: rtl/run_controller.sv
// run_controller: loads a program image into ROM, runs the CPU and captures a watched result write
//   clk, reset                    : rising-edge clock, asynchronous active-high reset
//   start                         : begins a load from IDLE or DONE
//   load_valid/ready/data/last    : program word stream into ROM
//   rom_we/rom_addr/rom_wdata     : ROM write port (program words, then padding)
//   cpu_reset                     : CPU reset, released only while running
//   mem_we/mem_addr/mem_wdata     : snooped CPU data-memory write bus
//   busy/done/timeout/result/cycles : run status and outcome
module run_controller #(
    parameter int WORD_W       = 16,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int MEM_ADDR_W   = 8,
    parameter int WATCH_ADDR   = 0,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 500,
    parameter int CNT_W        = 16,
    parameter int PAD_WORD     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WORD_W-1:0]     load_data,
    input  logic                  load_last,
    output logic                  rom_we,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic [WORD_W-1:0]     rom_wdata,
    output logic                  cpu_reset,
    input  logic                  mem_we,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [DATA_W-1:0]     result,
    output logic [CNT_W-1:0]      cycles
);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LOAD, PAD, HOLD, RUN, DONE} state_t;
    state_t state;
    logic [ADDR_W-1:0] ptr;
    logic [HOLD_W-1:0] hcnt;
    logic [CNT_W-1:0] cnt;
    logic ptr_end, watch_hit;
    assign ptr_end    = ptr == '1;
    assign watch_hit  = mem_we && mem_addr == MEM_ADDR_W'(WATCH_ADDR);
    assign load_ready = state == LOAD;
    assign busy       = state inside {LOAD, PAD, HOLD, RUN};
    assign done       = state == DONE;
    assign cpu_reset  = state != RUN;
    // ROM port follows the load stream directly in LOAD; PAD fills the rest
    assign rom_we     = (load_ready && load_valid) || state == PAD;
    assign rom_addr   = (load_ready || state == PAD) ? ptr : '0;
    assign rom_wdata  = load_ready ? load_data : state == PAD ? WORD_W'(PAD_WORD) : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
            result  <= '0;
            cycles  <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state   <= LOAD;
                    ptr     <= '0;
                    timeout <= 1'b0;
                    result  <= '0;
                    cycles  <= '0;
                end
                LOAD: if (load_valid) begin
                    ptr <= ptr + 1'b1;
                    // the last ROM word skips padding because the pointer wraps
                    if (load_last || ptr_end) state <= ptr_end ? HOLD : PAD;
                end
                PAD: begin
                    ptr <= ptr + 1'b1;
                    if (ptr_end) state <= HOLD;
                end
                HOLD: if (hcnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    hcnt  <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
                RUN: if (watch_hit) begin
                    // a watch write on the final budget cycle still counts as success
                    result  <= mem_wdata;
                    cycles  <= cnt + 1'b1;
                    timeout <= 1'b0;
                    state   <= DONE;
                end else if (cnt + 1'b1 == CNT_W'(MAX_CYCLES)) begin
                    timeout <= 1'b1;
                    cycles  <= CNT_W'(MAX_CYCLES);
                    state   <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: randomized self-checking bench for run_controller
module tb_run_controller;
    localparam int DEPTH = 64;
    localparam int MAXC  = 500;
    localparam int HOLDC = 2;
    logic clk = 1'b0;
    logic reset, start, load_valid, load_last, load_ready, rom_we, cpu_reset;
    logic mem_we, busy, done, timeout;
    logic [15:0] load_data, rom_wdata, mem_wdata, result, cycles;
    logic [5:0] rom_addr;
    logic [7:0] mem_addr;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] prog [DEPTH];
    logic [15:0] rom_img [DEPTH];
    int wr_cnt [DEPTH];

    always #5 clk = ~clk;

    run_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_reset(cpu_reset),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .timeout(timeout), .result(result), .cycles(cycles)
    );

    task automatic load_prog(input int n, input bit last, input bit stall);
        int pos = 0;
        int g = 0;
        int pad = 0;
        int hold = 0;
        bit v;
        logic [15:0] exp_w;
        for (int i = 0; i < DEPTH; i++) begin
            prog[i] = 16'($urandom);
            wr_cnt[i] = 0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if ({done, timeout, result, cycles, load_ready, cpu_reset} !== {2'b00, 32'h0, 2'b11}) begin
            n_fail++;
            $display("FAIL start_clear done=%b timeout=%b result=%h cycles=%0d ready=%b cpu_reset=%b",
                     done, timeout, result, cycles, load_ready, cpu_reset);
        end
        while (pos < n && g < 1000) begin
            v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            load_valid = v;
            load_data = prog[pos];
            load_last = last && pos == n - 1;
            start = stall && $urandom_range(0, 5) == 0;
            #1;
            n_chk++;
            if (load_ready !== 1'b1 || cpu_reset !== 1'b1 || rom_we !== v || rom_addr !== 6'(pos)
                || (v && rom_wdata !== prog[pos])) begin
                n_fail++;
                $display("FAIL load_word pos=%0d ready=%b cpu_reset=%b rom_we=%b (want %b) rom_addr=%0d rom_wdata=%h",
                         pos, load_ready, cpu_reset, rom_we, v, rom_addr, rom_wdata);
            end
            if (rom_we) begin
                rom_img[rom_addr] = rom_wdata;
                wr_cnt[rom_addr]++;
            end
            @(negedge clk);
            if (v) pos++;
            g++;
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        start = 1'b0;
        n_chk++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_last load_ready=%b want 0", load_ready);
        end
        g = 0;
        while (cpu_reset === 1'b1 && g < 200) begin
            n_chk++;
            if (busy !== 1'b1 || load_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL pad_hold_flags busy=%b load_ready=%b", busy, load_ready);
            end
            if (rom_we) begin
                pad++;
                rom_img[rom_addr] = rom_wdata;
                wr_cnt[rom_addr]++;
            end else begin
                hold++;
            end
            @(negedge clk);
            g++;
        end
        n_chk++;
        if (pad != DEPTH - n) begin
            n_fail++;
            $display("FAIL pad_cycles got %0d want %0d", pad, DEPTH - n);
        end
        n_chk++;
        if (hold != HOLDC) begin
            n_fail++;
            $display("FAIL hold_cycles got %0d want %0d", hold, HOLDC);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_w = i < n ? prog[i] : 16'h0000;
            n_chk++;
            if (rom_img[i] !== exp_w || wr_cnt[i] != 1) begin
                n_fail++;
                $display("FAIL rom_word addr=%0d got %h x%0d want %h x1", i, rom_img[i], wr_cnt[i], exp_w);
            end
        end
    endtask

    task automatic run_check(input int watch, input int stray, input int ign_start, input logic [15:0] wdata);
        int r = 1;
        int end_r;
        bit expt;
        logic [15:0] expres;
        expt = !(watch >= 1 && watch <= MAXC);
        end_r = expt ? MAXC : watch;
        expres = expt ? 16'h0000 : wdata;
        while (r <= MAXC + 20) begin
            mem_we = r == watch || r == stray;
            mem_addr = r == watch ? 8'd0 : 8'd3;
            mem_wdata = r == watch ? wdata : 16'($urandom);
            start = r == ign_start;
            @(negedge clk);
            if (done === 1'b1) break;
            n_chk++;
            if (cpu_reset !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL run_flags cycle=%0d cpu_reset=%b busy=%b", r, cpu_reset, busy);
            end
            r++;
        end
        mem_we = 1'b0;
        start = 1'b0;
        n_chk++;
        if (r != end_r) begin
            n_fail++;
            $display("FAIL done_cycle got %0d want %0d", r, end_r);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if ({done, busy, cpu_reset, timeout, result, cycles} !== {3'b101, expt, expres, 16'(end_r)}) begin
            n_fail++;
            $display("FAIL run_outcome done=%b busy=%b cpu_reset=%b timeout=%b result=%h cycles=%0d want timeout=%b result=%h cycles=%0d",
                     done, busy, cpu_reset, timeout, result, cycles, expt, expres, end_r);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({load_ready, rom_we, busy, done, timeout, cpu_reset, rom_addr, rom_wdata, result, cycles}
            !== {5'b00000, 1'b1, 6'd0, 48'd0}) begin
            n_fail++;
            $display("FAIL reset_values ready=%b we=%b busy=%b done=%b timeout=%b cpu_reset=%b addr=%0d wdata=%h result=%h cycles=%0d",
                     load_ready, rom_we, busy, done, timeout, cpu_reset, rom_addr, rom_wdata, result, cycles);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, cpu_reset, load_ready} !== 4'b0010) begin
            n_fail++;
            $display("FAIL idle_values busy=%b done=%b cpu_reset=%b ready=%b", busy, done, cpu_reset, load_ready);
        end
    endtask

    task automatic test_load_pad;
        load_prog(42, 1'b1, 1'b0);
        run_check(10, -1, -1, 16'h0037);
    endtask

    task automatic test_timeout;
        load_prog(7, 1'b1, 1'b1);
        run_check(0, 100, 50, 16'h1234);
    endtask

    task automatic test_watch_at_budget;
        load_prog(20, 1'b1, 1'b0);
        run_check(MAXC, 250, -1, 16'($urandom));
    endtask

    task automatic test_full_rom;
        load_prog(DEPTH, 1'b0, 1'b1);
        run_check(int'($urandom_range(1, 50)), -1, -1, 16'($urandom));
        load_prog(DEPTH, 1'b1, 1'b0);
        run_check(1, -1, -1, 16'($urandom));
    endtask

    task automatic test_reset_midrun;
        load_prog(5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({load_ready, rom_we, busy, done, timeout, cpu_reset, rom_addr, rom_wdata, result, cycles}
            !== {5'b00000, 1'b1, 6'd0, 48'd0}) begin
            n_fail++;
            $display("FAIL async_reset ready=%b we=%b busy=%b done=%b timeout=%b cpu_reset=%b addr=%0d result=%h cycles=%0d",
                     load_ready, rom_we, busy, done, timeout, cpu_reset, rom_addr, result, cycles);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_prog(3, 1'b1, 1'b1);
        run_check(int'($urandom_range(2, 30)), 1, -1, 16'($urandom));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        load_data = '0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        test_reset();
        test_load_pad();
        test_timeout();
        test_watch_at_budget();
        test_full_rom();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable program-load and run supervisor for mod_cpu.
- Streams a program image into instruction ROM and pads unused ROM words with a fixed value.
- Holds the CPU in reset during load, releases it, and snoops the data-memory write bus for a result write to a watch address.
- Reports result, cycle count and timeout; replaces fixed-length bench runs with a bounded, self-terminating run.

Parameters:
- WORD_W, 16, ROM word width.
- ADDR_W, 6, ROM address width; ROM depth is 2**ADDR_W.
- DATA_W, 16, data-memory word width.
- MEM_ADDR_W, 8, data-memory address width.
- WATCH_ADDR, 0, data-memory address whose write ends the run.
- RESET_CYCLES, 2, CPU reset hold after load (at least 1).
- MAX_CYCLES, 500, run-cycle budget before timeout (at least 1).
- CNT_W, 16, cycle counter width (2**CNT_W > MAX_CYCLES).
- PAD_WORD, 0, value written to ROM words after the last loaded word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins load when IDLE or DONE.
- load_valid  in  1  program word valid.
- load_ready  out  1  controller accepts a word.
- load_data  in  WORD_W  program word.
- load_last  in  1  marks final program word.
- rom_we  out  1  ROM write strobe.
- rom_addr  out  ADDR_W  ROM write address.
- rom_wdata  out  WORD_W  ROM write data.
- cpu_reset  out  1  reset to mod_cpu, active-high.
- mem_we  in  1  snooped CPU data-memory write enable.
- mem_addr  in  MEM_ADDR_W  snooped write address.
- mem_wdata  in  DATA_W  snooped write data.
- busy  out  1  high in LOAD, PAD, HOLD and RUN.
- done  out  1  high in DONE.
- timeout  out  1  valid while done; 1 means the budget was exhausted.
- result  out  DATA_W  captured mem_wdata.
- cycles  out  CNT_W  number of RUN cycles used.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - load_ready, rom_we, busy, done and timeout go to 0.
  - rom_addr, rom_wdata, result and cycles go to 0.
  - cpu_reset goes to 1.
  - Internal address pointer and counters clear.
- States: IDLE, LOAD, PAD, HOLD, RUN, DONE.
- IDLE: cpu_reset=1. start moves to LOAD on the next edge with pointer=0.
- LOAD:
  - load_ready=1 and cpu_reset=1.
  - A word is accepted on an edge where load_valid and load_ready are both high.
  - rom_we equals load_valid; rom_addr is the pointer; rom_wdata is load_data. All three are combinational in LOAD.
  - On each accepted word the pointer increments.
  - Accepting a word with load_last, or the word at address 2**ADDR_W-1, ends LOAD.
  - If the pointer wraps to 0 (ROM full), go to HOLD; otherwise go to PAD.
  - load_valid low stalls LOAD indefinitely with no timeout.
- PAD:
  - load_ready=0, rom_we=1, rom_wdata=PAD_WORD.
  - rom_addr steps by one address per cycle.
  - After the write to 2**ADDR_W-1, go to HOLD.
- HOLD: cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN:
  - cpu_reset=0. The cycle counter starts at 0 on the first RUN cycle and increments every RUN cycle.
  - On an edge with mem_we=1 and mem_addr=WATCH_ADDR: result<=mem_wdata, cycles<=count+1, timeout<=0, go to DONE.
  - Otherwise, on the edge where count+1 equals MAX_CYCLES: timeout<=1, cycles<=MAX_CYCLES, go to DONE.
  - If a watch write and the budget expiry coincide, the watch write wins (timeout=0, result captured).
  - Writes to other addresses are ignored.
- DONE:
  - done=1, busy=0, cpu_reset=1 (CPU frozen).
  - result, cycles and timeout hold until the next start or reset.
  - start in DONE clears done, timeout, result and cycles, and goes to LOAD.
- start in LOAD, PAD, HOLD or RUN is ignored.
- Reset asserted mid-LOAD or mid-RUN aborts immediately. ROM contents already written are not cleared.

Test Plan:
- Load 42 words (ADDR_W=6), last on word 41 -> rom_we for addr 0..41 with data, then addr 42..63 with PAD_WORD 0 (22 cycles); cpu_reset high throughout load/pad plus 2 HOLD cycles.
- In RUN, drive mem_we=1, mem_addr=0, mem_wdata=0x0037 on the 10th RUN cycle -> done=1, result=0x0037, cycles=10, timeout=0, cpu_reset=1.
- No watch write with MAX_CYCLES=500 -> done after 500 RUN cycles, timeout=1, cycles=500; a write to addr 3 in between is ignored.
- Watch write on RUN cycle 500 -> timeout=0, result captured, cycles=500.
- Load 64 words without load_last -> no PAD cycles, direct to HOLD; load_ready low after word 63; toggling load_valid between words stalls the pointer.
- Assert reset during RUN cycle 5, then start after release -> all outputs at reset values immediately, cpu_reset=1; a fresh load begins at addr 0.
